// File: rtl/regfile_multiport_if.sv
// rtl/regfile_multiport_if.sv - write/read port bundle for the multiport register file
interface regfile_multiport_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic                           ready;
  logic                           write_enable_a;
  logic [ADDR_WIDTH-1:0]          address_write_a;
  logic [WIDTH-1:0]               write_data_a;
  logic                           write_enable_b;
  logic [ADDR_WIDTH-1:0]          address_write_b;
  logic [WIDTH-1:0]               write_data_b;
  logic [NUM_READ*ADDR_WIDTH-1:0] address_read;
  logic [NUM_READ*WIDTH-1:0]      read_data;

  modport master (
    input  ready, read_data,
    output write_enable_a, address_write_a, write_data_a,
    output write_enable_b, address_write_b, write_data_b,
    output address_read
  );

  modport slave (
    output ready, read_data,
    input  write_enable_a, address_write_a, write_data_a,
    input  write_enable_b, address_write_b, write_data_b,
    input  address_read
  );
endinterface

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - DEPTH x WIDTH register file, two write ports, NUM_READ combinational reads
// After reset a sequencer zeroes one entry per cycle; ready stays low until the last entry is cleared.
module regfile_multiport #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG0  = 1,
  parameter int BYPASS     = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  regfile_multiport_if.slave bus
);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

  state_t                    r_state;
  logic                      r_ready;
  logic [ADDR_WIDTH-1:0]     r_clear_index;
  logic [WIDTH-1:0]          r_mem [DEPTH];

  logic                      w_wr_a_ok;
  logic                      w_wr_b_ok;
  logic [NUM_READ*WIDTH-1:0] w_read_data;
  logic [ADDR_WIDTH-1:0]     w_rd_addr;
  logic [WIDTH-1:0]          w_rd_word;

  // An address is storable when it maps to a real entry and is not the hardwired zero register.
  function automatic logic addr_storable(input logic [ADDR_WIDTH-1:0] addr);
    return ({1'b0, addr} < DEPTH_EXT) && !((ZERO_REG0 != 0) && (addr == '0));
  endfunction

  assign w_wr_a_ok = (r_state == ST_READY) && bus.write_enable_a && addr_storable(bus.address_write_a);
  assign w_wr_b_ok = (r_state == ST_READY) && bus.write_enable_b && addr_storable(bus.address_write_b);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= ST_CLEAR;
      r_clear_index <= '0;
      r_ready       <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_mem[r_clear_index] <= '0;
          if (r_clear_index == LAST_IDX) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end else begin
            r_clear_index <= r_clear_index + 1'b1;
          end
        end
        ST_READY: begin
          for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_b_ok && (bus.address_write_b == ADDR_WIDTH'(i))) begin
              r_mem[i] <= bus.write_data_b;
            end else if (w_wr_a_ok && (bus.address_write_a == ADDR_WIDTH'(i))) begin
              r_mem[i] <= bus.write_data_a;
            end
          end
        end
        default: begin
          r_state <= ST_CLEAR;
        end
      endcase
    end
  end

  // Reads are forced to zero while clearing, so partially cleared storage never leaks out.
  always_comb begin
    w_read_data = '0;
    w_rd_addr   = '0;
    w_rd_word   = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      w_rd_addr = bus.address_read[p*ADDR_WIDTH +: ADDR_WIDTH];
      w_rd_word = '0;
      if ((r_state == ST_READY) && addr_storable(w_rd_addr)) begin
        if ((BYPASS != 0) && w_wr_b_ok && (bus.address_write_b == w_rd_addr)) begin
          w_rd_word = bus.write_data_b;
        end else if ((BYPASS != 0) && w_wr_a_ok && (bus.address_write_a == w_rd_addr)) begin
          w_rd_word = bus.write_data_a;
        end else begin
          w_rd_word = r_mem[w_rd_addr];
        end
      end
      w_read_data[p*WIDTH +: WIDTH] = w_rd_word;
    end
  end

  assign bus.ready     = r_ready;
  assign bus.read_data = w_read_data;

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - bench for regfile_multiport: default build plus DEPTH=24, no zero reg, no bypass
module tb_regfile_multiport;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  regfile_multiport_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus_m ();
  regfile_multiport_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus_a ();

  regfile_multiport #(.WIDTH(W), .DEPTH(32), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG0(1), .BYPASS(1))
    u_dut (.clock(clock), .reset_n(reset_n), .bus(bus_m));
  regfile_multiport #(.WIDTH(W), .DEPTH(24), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG0(0), .BYPASS(0))
    u_alt (.clock(clock), .reset_n(reset_n), .bus(bus_a));

  typedef struct {
    logic        wea; logic [4:0] aa; logic [31:0] da;
    logic        web; logic [4:0] ab; logic [31:0] db;
    logic [4:0]  r0;  logic [4:0] r1;
    logic [31:0] e0;  logic [31:0] e1;
  } vec_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  vec_t        vecs [12];
  sb_t         sb_q [$];
  logic [31:0] main_model [32];
  logic [31:0] alt_model  [24];
  int          checks = 0;
  int          errors = 0;

  logic        cur_wea, cur_web;
  logic [4:0]  cur_aa, cur_ab, cur_r0, cur_r1;
  logic [31:0] cur_da, cur_db;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_act(input int sel);
    case (sel)
      0:       return bus_m.read_data[31:0];
      1:       return bus_m.read_data[63:32];
      2:       return bus_a.read_data[31:0];
      default: return bus_a.read_data[63:32];
    endcase
  endfunction

  function automatic logic [31:0] alt_rd(input logic [4:0] a);
    return (a >= 5'd24) ? 32'h0 : alt_model[a];
  endfunction

  function automatic logic [31:0] main_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : main_model[a];
  endfunction

  task automatic drive(input logic wea, input logic [4:0] aa, input logic [31:0] da,
                       input logic web, input logic [4:0] ab, input logic [31:0] db,
                       input logic [4:0] r0, input logic [4:0] r1);
    cur_wea = wea; cur_aa = aa; cur_da = da;
    cur_web = web; cur_ab = ab; cur_db = db;
    cur_r0 = r0; cur_r1 = r1;
    bus_m.write_enable_a = wea; bus_m.address_write_a = aa; bus_m.write_data_a = da;
    bus_m.write_enable_b = web; bus_m.address_write_b = ab; bus_m.write_data_b = db;
    bus_m.address_read   = {r1, r0};
    bus_a.write_enable_a = wea; bus_a.address_write_a = aa; bus_a.write_data_a = da;
    bus_a.write_enable_b = web; bus_a.address_write_b = ab; bus_a.write_data_b = db;
    bus_a.address_read   = {r1, r0};
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
  endtask

  task automatic push(input string name, input int sel, input logic [31:0] exp);
    sb_t e;
    e.name = name; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sample();
    sb_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.name, rd_act(e.sel), e.exp);
    end
  endtask

  task automatic commit_models();
    if (cur_wea && cur_aa != 5'd0) main_model[cur_aa] = cur_da;
    if (cur_web && cur_ab != 5'd0) main_model[cur_ab] = cur_db;
    if (cur_wea && cur_aa < 5'd24) alt_model[cur_aa] = cur_da;
    if (cur_web && cur_ab < 5'd24) alt_model[cur_ab] = cur_db;
  endtask

  task automatic zero_models();
    for (int i = 0; i < 32; i++) main_model[i] = 32'h0;
    for (int i = 0; i < 24; i++) alt_model[i] = 32'h0;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Called at a negedge right after reset_n goes high; writes are hammered to prove they are ignored.
  task automatic run_clear(input string tag, input int abort_after);
    int last;
    last = (abort_after > 0) ? abort_after : 32;
    for (int e = 1; e <= last; e++) begin
      if (e <= 20) drive(1'b1, 5'd1, 32'hBAD00001, 1'b1, 5'd2, 32'hBAD00002, 5'd1, 5'd2);
      else idle();
      if (e == 1 || e == 12) begin
        for (int s = 0; s < 4; s++) push($sformatf("%s_clr_rd%0d_e%0d", tag, s, e), s, 32'h0);
        sample();
      end
      @(posedge clock);
      #1;
      chk($sformatf("%s_ready_m_e%0d", tag, e), {31'h0, bus_m.ready}, {31'h0, (e >= 32)});
      chk($sformatf("%s_ready_a_e%0d", tag, e), {31'h0, bus_a.ready}, {31'h0, (e >= 24)});
      @(negedge clock);
    end
    if (abort_after > 0) begin
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      chk({tag, "_abort_ready_m"}, {31'h0, bus_m.ready}, 32'h0);
      chk({tag, "_abort_ready_a"}, {31'h0, bus_a.ready}, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
    end
    idle();
  endtask

  task automatic sweep(input string tag);
    logic [4:0] a, b;
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      b = 5'(31 - i);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, a, b);
      push($sformatf("%s_m_r%0d", tag, i), 0, main_rd(a));
      push($sformatf("%s_m_r%0d", tag, 31 - i), 1, main_rd(b));
      push($sformatf("%s_a_r%0d", tag, i), 2, alt_rd(a));
      push($sformatf("%s_a_r%0d", tag, 31 - i), 3, alt_rd(b));
      sample();
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 5'd7,  32'h11111111, 1'b1, 5'd7,  32'h22222222, 5'd7,  5'd7,  32'h22222222, 32'h22222222};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h22222222, 32'h22222222};
    vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[6]  = '{1'b1, 5'd30, 32'h01020304, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h01020304};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd30, 5'd31, 32'h01020304, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 5'd5,  32'h0,        1'b1, 5'd6,  32'hAAAA5555, 5'd6,  5'd5,  32'hAAAA5555, 32'h0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'h0,        32'hAAAA5555};
    vecs[10] = '{1'b1, 5'd23, 32'h13572468, 1'b1, 5'd30, 32'h12345678, 5'd23, 5'd30, 32'h13572468, 32'h12345678};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd23, 5'd30, 32'h13572468, 32'h12345678};

    zero_models();
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    chk("reset_ready_m", {31'h0, bus_m.ready}, 32'h0);
    chk("reset_ready_a", {31'h0, bus_a.ready}, 32'h0);
    reset_n = 1'b1;
    run_clear("init", 0);
    sweep("init_zero");

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].wea, vecs[i].aa, vecs[i].da, vecs[i].web, vecs[i].ab, vecs[i].db, vecs[i].r0, vecs[i].r1);
      push($sformatf("vec%0d_m_p0", i), 0, vecs[i].e0);
      push($sformatf("vec%0d_m_p1", i), 1, vecs[i].e1);
      push($sformatf("vec%0d_a_p0", i), 2, alt_rd(vecs[i].r0));
      push($sformatf("vec%0d_a_p1", i), 3, alt_rd(vecs[i].r1));
      sample();
      commit_models();
      tick();
    end
    idle();

    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), i, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      commit_models();
      tick();
    end
    idle();
    sweep("fill");

    reset_n = 1'b0;
    @(posedge clock);
    #1;
    chk("ready_drop_m", {31'h0, bus_m.ready}, 32'h0);
    chk("ready_drop_a", {31'h0, bus_a.ready}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    run_clear("abort", 10);
    run_clear("restart", 0);
    zero_models();
    sweep("after_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
